// File: rtl/map_arbiter_if.sv
// Purpose: bundles the two lookup requesters, the hold gate and the map_rom port of map_arbiter.
// Latency: wiring only, no logic of its own.
// Backpressure: requesters hold req and address until they see gnt; hold blocks new grants.
//
// Port summary (slave = arbiter side, master = requester/ROM side):
//   t_req/t_row/t_col -> t_gnt, t_valid   tracer lookup channel
//   o_req/o_row/o_col -> o_gnt, o_valid   overlay/debug lookup channel
//   hold                                  suppresses new grants while high
//   rom_row/rom_col -> rom_val            registered address out, combinational cell value back
//   rd_val, busy                          shared lookup result, in-flight indicator
interface map_arbiter_if #(
    parameter int BITS = 2
);
    logic            t_req;
    logic [3:0]      t_row;
    logic [3:0]      t_col;
    logic            t_gnt;
    logic            t_valid;

    logic            o_req;
    logic [3:0]      o_row;
    logic [3:0]      o_col;
    logic            o_gnt;
    logic            o_valid;

    logic            hold;

    logic [3:0]      rom_row;
    logic [3:0]      rom_col;
    logic [BITS-1:0] rom_val;

    logic [BITS-1:0] rd_val;
    logic            busy;

    modport slave (
        input  t_req, t_row, t_col,
        input  o_req, o_row, o_col,
        input  hold,
        input  rom_val,
        output t_gnt, t_valid,
        output o_gnt, o_valid,
        output rom_row, rom_col,
        output rd_val, busy
    );

    modport master (
        output t_req, t_row, t_col,
        output o_req, o_row, o_col,
        output hold,
        output rom_val,
        input  t_gnt, t_valid,
        input  o_gnt, o_valid,
        input  rom_row, rom_col,
        input  rd_val, busy
    );
endinterface

// File: rtl/map_arbiter.sv
// Purpose: round-robin sharing of the single map_rom lookup port between tracer (T) and overlay (O).
// Latency: grant in cycle N, registered address in N+1, valid pulse with rd_val in N+2; 1 lookup/cycle.
// Backpressure: requester holds req until its combinational gnt; hold gates grants, in-flight lookups finish.
//
// Ports: clk, reset_n (async, active-low) plus the slave side of map_arbiter_if
//        (request channels, hold, rom address/value, rd_val, busy).
module map_arbiter #(
    parameter int BITS = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    map_arbiter_if.slave bus
);

    typedef enum logic {
        REQ_T = 1'b0,
        REQ_O = 1'b1
    } req_id_e;

    // Round-robin pointer: the requester granted most recently.
    req_id_e         last_q;
    req_id_e         last_d;

    // Stage 1: address presented to map_rom plus the tag of the lookup it belongs to.
    logic [3:0]      rom_row_q;
    logic [3:0]      rom_row_d;
    logic [3:0]      rom_col_q;
    logic [3:0]      rom_col_d;
    logic            s1_vld_q;
    logic            s1_vld_d;
    req_id_e         s1_id_q;
    req_id_e         s1_id_d;

    // Stage 2: captured cell value and per-requester valid pulses.
    logic [BITS-1:0] rd_val_q;
    logic [BITS-1:0] rd_val_d;
    logic            t_valid_q;
    logic            t_valid_d;
    logic            o_valid_q;
    logic            o_valid_d;

    logic            t_win;
    logic            o_win;

    // Grant decision. This is the only combinational path to outputs:
    // req/hold/last_q -> gnt. On a tie the requester that did not win last time goes.
    always_comb begin : grant_logic
        t_win = 1'b0;
        o_win = 1'b0;
        if (!bus.hold) begin
            if (bus.t_req && bus.o_req) begin
                t_win = (last_q == REQ_O);
                o_win = (last_q == REQ_T);
            end else begin
                t_win = bus.t_req;
                o_win = bus.o_req;
            end
        end
    end

    always_comb begin : next_state
        last_d    = last_q;
        rom_row_d = rom_row_q;
        rom_col_d = rom_col_q;
        s1_id_d   = s1_id_q;
        s1_vld_d  = t_win | o_win;

        if (t_win) begin
            last_d    = REQ_T;
            rom_row_d = bus.t_row;
            rom_col_d = bus.t_col;
            s1_id_d   = REQ_T;
        end else if (o_win) begin
            last_d    = REQ_O;
            rom_row_d = bus.o_row;
            rom_col_d = bus.o_col;
            s1_id_d   = REQ_O;
        end

        // rom_val is settled one cycle after the address register changed, so it
        // is captured here; rd_val keeps the last result when nothing is in flight.
        rd_val_d  = s1_vld_q ? bus.rom_val : rd_val_q;
        t_valid_d = s1_vld_q & (s1_id_q == REQ_T);
        o_valid_d = s1_vld_q & (s1_id_q == REQ_O);
    end

    // Reset discards anything in flight; last_q starts at O so T wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q    <= REQ_O;
            rom_row_q <= 4'd0;
            rom_col_q <= 4'd0;
            s1_vld_q  <= 1'b0;
            s1_id_q   <= REQ_T;
            rd_val_q  <= '0;
            t_valid_q <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            rom_row_q <= rom_row_d;
            rom_col_q <= rom_col_d;
            s1_vld_q  <= s1_vld_d;
            s1_id_q   <= s1_id_d;
            rd_val_q  <= rd_val_d;
            t_valid_q <= t_valid_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign bus.t_gnt   = t_win;
    assign bus.o_gnt   = o_win;
    assign bus.rom_row = rom_row_q;
    assign bus.rom_col = rom_col_q;
    assign bus.rd_val  = rd_val_q;
    assign bus.t_valid = t_valid_q;
    assign bus.o_valid = o_valid_q;
    assign bus.busy    = s1_vld_q | t_valid_q | o_valid_q;

    // Structural guarantees of the arbiter.
    a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
        !(t_win && o_win));
    a_gnt_needs_req: assert property (@(posedge clk) disable iff (!reset_n)
        (!t_win || bus.t_req) && (!o_win || bus.o_req));
    a_hold_blocks: assert property (@(posedge clk) disable iff (!reset_n)
        bus.hold |-> !(t_win || o_win));

endmodule

// File: tb/tb_map_arbiter.sv
// Purpose: self-checking bench for map_arbiter with a map_rom model and a grant/result scoreboard.
// Latency: expects valid two cycles after each grant, results in grant order.
// Backpressure: stimulus holds req until the reference model says it was granted.
module tb_map_arbiter;

    localparam int BITS = 2;
    localparam int VW   = 13 + BITS;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    map_arbiter_if #(.BITS(BITS)) bus ();

    map_arbiter #(.BITS(BITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Map contents: walls (value 3) on the outer ring, interior cells = low bits of row^col.
    function automatic logic [BITS-1:0] map_cell(input logic [3:0] r, input logic [3:0] c);
        logic [3:0] x;
        if (r == 4'd0 || r == 4'd15 || c == 4'd0 || c == 4'd15) return 2'b11;
        x = r ^ c;
        return x[BITS-1:0];
    endfunction

    assign bus.rom_val = map_cell(bus.rom_row, bus.rom_col);

    // Reference model: a list of outstanding lookups, each with the cycle its result is due.
    typedef struct {
        int              due;
        bit              id;    // 0 = T, 1 = O
        logic [BITS-1:0] val;
    } pend_t;

    pend_t           pend_q[$];
    bit              m_last;    // requester granted most recently (1 = O)
    logic [BITS-1:0] m_rd;
    logic [3:0]      m_row;
    logic [3:0]      m_col;
    int              cyc = 0;

    logic e_tg, e_og, e_tv, e_ov, e_busy;

    int n_chk = 0;
    int n_bad = 0;

    task automatic drive(input logic tr, input logic [3:0] trow, input logic [3:0] tcol,
                         input logic orq, input logic [3:0] orow, input logic [3:0] ocol,
                         input logic h);
        bus.t_req = tr;
        bus.t_row = trow;
        bus.t_col = tcol;
        bus.o_req = orq;
        bus.o_row = orow;
        bus.o_col = ocol;
        bus.hold  = h;
    endtask

    task automatic model_reset();
        pend_q.delete();
        m_last = 1'b1;
        m_rd   = '0;
        m_row  = 4'd0;
        m_col  = 4'd0;
    endtask

    // Expected outputs for the current cycle, from the current inputs and past grants.
    task automatic model_eval();
        e_tv = 1'b0;
        e_ov = 1'b0;
        while (pend_q.size() > 0 && pend_q[0].due < cyc) void'(pend_q.pop_front());
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            e_tv = !pend_q[0].id;
            e_ov = pend_q[0].id;
            m_rd = pend_q[0].val;
        end
        e_busy = (pend_q.size() > 0);
        e_tg = 1'b0;
        e_og = 1'b0;
        if (!bus.hold) begin
            if (bus.t_req && bus.o_req) begin
                e_tg = m_last;
                e_og = !m_last;
            end else begin
                e_tg = bus.t_req;
                e_og = bus.o_req;
            end
        end
    endtask

    // Book this cycle's expected grant, then move to just after the next rising edge.
    task automatic advance();
        pend_t e;
        if (e_tg || e_og) begin
            e.due  = cyc + 2;
            e.id   = e_og;
            e.val  = e_tg ? map_cell(bus.t_row, bus.t_col) : map_cell(bus.o_row, bus.o_col);
            pend_q.push_back(e);
            m_last = e_og;
            m_row  = e_tg ? bus.t_row : bus.o_row;
            m_col  = e_tg ? bus.t_col : bus.o_col;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {bus.t_gnt, bus.o_gnt, bus.t_valid, bus.o_valid, bus.busy,
                bus.rd_val, bus.rom_row, bus.rom_col};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {e_tg, e_og, e_tv, e_ov, e_busy, m_rd, m_row, m_col};
    endfunction

    // Vector layout printed on failure: tg og tv ov busy rd_val rom_row rom_col

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            advance();
        end
        reset_n = 1'b1;
        @(negedge clk);
        model_eval();
        n_chk++;
        if (obs_vec() !== {VW{1'b0}}) begin
            n_bad++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs_vec(), {VW{1'b0}});
        end
        advance();
    endtask

    task automatic test_single(input logic [3:0] r, input logic [3:0] c, input logic [BITS-1:0] want);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1, r, c, 0, 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL single cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (i == 1) begin
                n_chk++;
                if ({bus.rom_row, bus.rom_col} !== {r, c}) begin
                    n_bad++;
                    $display("FAIL single_addr got=%h exp=%h", {bus.rom_row, bus.rom_col}, {r, c});
                end
            end
            if (i == 2) begin
                n_chk++;
                if ({bus.t_valid, bus.rd_val} !== {1'b1, want}) begin
                    n_bad++;
                    $display("FAIL single_result got=%b exp=%b", {bus.t_valid, bus.rd_val}, {1'b1, want});
                end
            end
            advance();
        end
    endtask

    task automatic test_contention();
        int tg_cnt = 0;
        int og_cnt = 0;
        int tv_cnt = 0;
        int ov_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(1, 4'($urandom_range(15)), 4'($urandom_range(15)),
                             1, 4'($urandom_range(15)), 4'($urandom_range(15)), 0);
            else       drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL contention cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            tg_cnt += int'(bus.t_gnt);
            og_cnt += int'(bus.o_gnt);
            tv_cnt += int'(bus.t_valid);
            ov_cnt += int'(bus.o_valid);
            advance();
        end
        n_chk++;
        if ({tg_cnt, og_cnt, tv_cnt, ov_cnt} !== {32'd4, 32'd4, 32'd4, 32'd4}) begin
            n_bad++;
            $display("FAIL contention_counts got=%0d/%0d/%0d/%0d exp=4/4/4/4", tg_cnt, og_cnt, tv_cnt, ov_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int og_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(0, 0, 0, 1, 4'(i * 4 + int'($urandom_range(3))), 4'($urandom_range(15)), 0);
            else       drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            n_chk++;
            if (bus.o_valid !== ((i >= 2 && i <= 5) ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL b2b_valid i=%0d got=%b", i, bus.o_valid);
            end
            og_cnt += int'(bus.o_gnt);
            advance();
        end
        n_chk++;
        if (og_cnt != 4) begin
            n_bad++;
            $display("FAIL b2b_grants got=%0d exp=4", og_cnt);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       drive(1, 4'd3, 4'd6, 0, 0, 0, 0);
                1, 2, 3: drive(1, 4'd2, 4'd9, 1, 4'd11, 4'd4, 1);
                4:       drive(1, 4'd2, 4'd9, 1, 4'd11, 4'd4, 0);
                5:       drive(1, 4'd2, 4'd9, 0, 0, 0, 0);
                default: drive(0, 0, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL hold cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (i >= 1 && i <= 3) begin
                n_chk++;
                if ({bus.t_gnt, bus.o_gnt} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL hold_grant i=%0d got=%b exp=00", i, {bus.t_gnt, bus.o_gnt});
                end
            end
            if (i == 2) begin
                n_chk++;
                if (bus.t_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL hold_inflight got=%b exp=1", bus.t_valid);
                end
            end
            if (i == 3) begin
                n_chk++;
                if (bus.busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL hold_busy got=%b exp=0", bus.busy);
                end
            end
            if (i == 4) begin
                n_chk++;
                if ({bus.t_gnt, bus.o_gnt} !== 2'b01) begin
                    n_bad++;
                    $display("FAIL hold_release got=%b exp=01", {bus.t_gnt, bus.o_gnt});
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        drive(1, 4'd7, 4'd9, 0, 0, 0, 0);
        @(negedge clk);
        model_eval();
        n_chk++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL midrst_grant cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
        end
        advance();
        // Cycle N+1: lookup is in stage 1 when reset hits.
        drive(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        model_reset();
        #1;
        model_eval();
        n_chk++;
        if (obs_vec() !== {VW{1'b0}}) begin
            n_bad++;
            $display("FAIL midrst_clear got=%b exp=%b", obs_vec(), {VW{1'b0}});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs_vec() !== exp_vec() || bus.t_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_hold cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            advance();
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1, 4'd1, 4'd2, 1, 4'd3, 4'd4, 0);
            else if (i == 1) drive(0, 0, 0, 1, 4'd3, 4'd4, 0);
            else drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL midrst_after cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (i == 0) begin
                n_chk++;
                if ({bus.t_gnt, bus.o_gnt} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL midrst_first_tie got=%b exp=10", {bus.t_gnt, bus.o_gnt});
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic       t_p = 1'b0;
        logic       o_p = 1'b0;
        logic [3:0] tr = 4'd0, tc = 4'd0, orr = 4'd0, oc = 4'd0;
        for (int i = 0; i < 83; i++) begin
            if (i < 80) begin
                if ((!t_p && $urandom_range(2) != 0) || (t_p && $urandom_range(3) == 0)) begin
                    t_p = 1'b1;
                    tr  = 4'($urandom_range(15));
                    tc  = 4'($urandom_range(15));
                end
                if ((!o_p && $urandom_range(2) != 0) || (o_p && $urandom_range(3) == 0)) begin
                    o_p = 1'b1;
                    orr = 4'($urandom_range(15));
                    oc  = 4'($urandom_range(15));
                end
                drive(t_p, tr, tc, o_p, orr, oc, ($urandom_range(4) == 0));
            end else begin
                drive(0, 0, 0, 0, 0, 0, 0);
            end
            @(negedge clk);
            model_eval();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            if (e_tg) t_p = 1'b0;
            if (e_og) o_p = 1'b0;
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single(4'd0, 4'd0, 2'b11);
        test_single(4'd5, 4'd5, 2'b00);
        test_contention();
        test_back_to_back();
        test_hold();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
